// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if: start requests and iteration/counter controls of the multiply/divide sequencer.
interface multdiv_sequencer_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        busy;
  logic        op_mult;
  logic        step_en;
  logic        first_step;
  logic [5:0]  iter;
  logic        data_resultRDY;
  logic [31:0] cnt_wdata;
  logic        cnt_we;
  logic        cnt_oe;
  modport master (
    output ctrl_MULT, ctrl_DIV,
    input  busy, op_mult, step_en, first_step, iter, data_resultRDY, cnt_wdata, cnt_we, cnt_oe
  );
  modport slave (
    input  ctrl_MULT, ctrl_DIV,
    output busy, op_mult, step_en, first_step, iter, data_resultRDY, cnt_wdata, cnt_we, cnt_oe
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: IDLE/RUN/DONE control FSM stepping an iterative multiplier/divider datapath.
module multdiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input logic               clock,
  input logic               reset,
  multdiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state;
  logic [5:0]  r_iter;
  logic        r_op;
  logic        r_busy;
  logic        r_first;
  logic        r_rdy;
  logic [31:0] r_wdata;
  logic        w_start;
  logic [5:0]  w_last_iter;
  logic        w_last;
  assign w_start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_last_iter = r_op ? 6'(MULT_CYCLES - 1) : 6'(DIV_CYCLES - 1);
  assign w_last      = r_iter == w_last_iter;
  // a start in any state restarts; cnt_wdata is precomputed one cycle ahead so it stays registered
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_iter  <= '0;
      r_op    <= 1'b0;
      r_busy  <= 1'b0;
      r_first <= 1'b0;
      r_rdy   <= 1'b0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_state <= RUN;
      r_iter  <= '0;
      r_op    <= bus.ctrl_MULT;
      r_busy  <= 1'b1;
      r_first <= 1'b1;
      r_rdy   <= 1'b0;
      r_wdata <= 32'd1;
    end else begin
      case (r_state)
        RUN: begin
          r_first <= 1'b0;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b1;
            r_wdata <= '0;
          end else begin
            r_iter  <= r_iter + 6'd1;
            r_wdata <= {26'b0, r_iter + 6'd2};
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_rdy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  assign bus.busy           = r_busy;
  assign bus.step_en        = r_busy;
  assign bus.cnt_we         = r_busy;
  assign bus.cnt_oe         = r_busy;
  assign bus.first_step     = r_first;
  assign bus.op_mult        = r_op;
  assign bus.iter           = r_iter;
  assign bus.data_resultRDY = r_rdy;
  assign bus.cnt_wdata      = r_wdata;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: two sequencers (32/32 and 32/5 cycles) checked every cycle against a start-time latency model.
module tb_multdiv_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic m = 1'b0;
  logic d = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  int edge_n = 0;
  int st[2] = '{-1, -1};
  bit opm[2] = '{1'b0, 1'b0};
  string tag = "reset";
  always #5 clock = ~clock;
  multdiv_sequencer_if ia ();
  multdiv_sequencer_if ib ();
  assign ia.ctrl_MULT = m;
  assign ia.ctrl_DIV  = d;
  assign ib.ctrl_MULT = m;
  assign ib.ctrl_DIV  = d;
  multdiv_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32)) ua (.clock(clock), .reset(reset), .bus(ia.slave));
  multdiv_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(5))  ub (.clock(clock), .reset(reset), .bus(ib.slave));
  task automatic check();
    logic [44:0] act[2];
    act[0] = {ia.busy, ia.step_en, ia.cnt_we, ia.cnt_oe, ia.first_step, ia.data_resultRDY, ia.op_mult, ia.iter, ia.cnt_wdata};
    act[1] = {ib.busy, ib.step_en, ib.cnt_we, ib.cnt_oe, ib.first_step, ib.data_resultRDY, ib.op_mult, ib.iter, ib.cnt_wdata};
    for (int i = 0; i < 2; i++) begin
      int n, k, e_iter, e_wdata;
      bit run, done, first;
      logic [44:0] exp;
      n = opm[i] ? 32 : (i == 1 ? 5 : 32);
      k = st[i] < 0 ? -1 : edge_n - st[i];
      run = k >= 0 && k < n;
      done = k == n;
      first = run && k == 0;
      e_iter = run ? k : (st[i] < 0 ? 0 : n - 1);
      e_wdata = run ? k + 1 : 0;
      exp = {run, run, run, run, first, done, opm[i], 6'(e_iter), 32'(e_wdata)};
      n_assert++;
      assert (act[i] === exp) else begin
        n_fail++;
        $error("FAIL %s dut%0d edge%0d: observed %h expected %h", tag, i, edge_n, act[i], exp);
      end
    end
  endtask
  task automatic step(input bit m_, input bit d_, input bit r_);
    m = m_;
    d = d_;
    reset = r_;
    @(posedge clock);
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (!r_) begin
        st[i] = -1;
        opm[i] = 1'b0;
      end else if (m_ | d_) begin
        st[i] = edge_n;
        opm[i] = m_;
      end
    end
    #1 check();
  endtask
  initial begin
    tag = "reset";
    step(1, 1, 0);
    step(0, 0, 0);
    tag = "mult";
    step(1, 0, 1);
    repeat (36) step(0, 0, 1);
    tag = "div";
    step(0, 1, 1);
    repeat (36) step(0, 0, 1);
    tag = "both";
    step(1, 1, 1);
    repeat (36) step(0, 0, 1);
    tag = "abort";
    step(0, 1, 1);
    repeat (9) step(0, 0, 1);
    step(1, 0, 1);
    repeat (36) step(0, 0, 1);
    tag = "rst_mid";
    step(1, 0, 1);
    repeat (14) step(0, 0, 1);
    step(0, 0, 0);
    repeat (40) step(0, 0, 1);
    tag = "done_start";
    step(1, 0, 1);
    repeat (32) step(0, 0, 1);
    step(0, 1, 1);
    repeat (36) step(0, 0, 1);
    tag = "random";
    repeat (3000) step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
